arbitro_mul: RTL
================

ARBITRO_MUL -- requirements
Module: arbitro_mul

Interface
REQ-001 Parameter ANCHO, default 4: operand width of the shared Booth multiplier.
REQ-002 Parameter TMAX, default 64: watchdog limit in cycles; used only under REQ-026.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 sol0, sol1  input  1 each  multiply request from requester 0/1, held until acep.
REQ-006 a0, b0, a1, b1  input  ANCHO each  signed multiplicand/multiplier, stable while sol high.
REQ-007 acep0, acep1  output  1 each  one-cycle accept pulse; operands captured this cycle.
REQ-008 res0, res1  output  2*ANCHO each  product, valid when listo pulses, held until overwritten.
REQ-009 listo0, listo1  output  1 each  one-cycle result-valid pulse.
REQ-010 error0, error1  output  1 each  one-cycle watchdog pulse, coincident with listo.
REQ-011 mul_start  output  1  one-cycle start to the external multiplier.
REQ-012 mul_a, mul_b  output  ANCHO each  latched operands, stable from LANZA until LIBRE.
REQ-013 mul_res  input  2*ANCHO  multiplier product.
REQ-014 mul_fin  input  1  multiplier done flag; level may stay high between operations.

Function
REQ-015 FSM states: LIBRE, LANZA, ESPERA, ENTREGA; all outputs registered.
REQ-016 LIBRE: no sol -> stay; any sol -> grant per REQ-017, latch operands, pulse acep_g, next LANZA.
REQ-017 Round-robin: single request wins; both requesting -> requester not served last wins; after reset requester 0 has priority.
REQ-018 LANZA: mul_start=1 for exactly one cycle, next ESPERA.
REQ-019 ESPERA: completion = rising edge of mul_fin (registered previous value low, current high); a level high carried from a previous operation SHALL NOT complete.
REQ-020 ESPERA on completion: capture mul_res into res_g, next ENTREGA.
REQ-021 ENTREGA: listo_g=1 one cycle, record g as last served, next LIBRE; non-granted outputs unchanged.
REQ-022 Throughput: back-to-back requests served with one LIBRE cycle between operations; minimum acep-to-listo latency = multiplier latency + 3 cycles.
REQ-023 sol dropped after acep has no effect on the operation in flight; sol of the other requester during an operation is held pending, never lost.
REQ-024 No arithmetic in this block; result width = 2*ANCHO, passed unmodified.

Reset
REQ-025 reset low: state LIBRE, last-served = 1 (so requester 0 wins first tie), all acep/listo/error/mul_start = 0, res0/res1/mul_a/mul_b = 0, fin-edge register = 1; mid-operation reset aborts with no listo.

Configuration
REQ-026 ARBITRO_MUL_WATCHDOG_EN defined: cycle counter in ESPERA; TMAX cycles without completion -> res_g=0, listo_g and error_g pulse together, next LIBRE via ENTREGA.
REQ-027 ARBITRO_MUL_WATCHDOG_EN undefined: no counter; ESPERA waits indefinitely; error0/error1 tied 0.

Structure
REQ-028 Shared package arbitro_mul_pkg holds the state enumeration and default ANCHO/TMAX constants.
REQ-029 Round-robin selection SHALL be sub-module prioridad_rr (inputs sol0, sol1, last-served; output grant index).
REQ-030 The multiplier is instantiated outside this block, at the parent level.

Verification
REQ-031 Single request: sol0, a0=3, b0=-2, model fin after 6 cycles -> acep0 one cycle, mul_start one cycle, listo0 with res0=8'hFA.
REQ-032 Simultaneous first requests after reset: sol0=sol1=1 -> requester 0 served first, then requester 1, one LIBRE cycle between.
REQ-033 Fairness: both hold sol for 4 operations -> grants alternate 0,1,0,1.
REQ-034 mul_fin stuck high from previous op -> no completion until it falls and rises again.
REQ-035 Watchdog build, TMAX=64, fin never rises -> listo1 and error1 at ESPERA cycle 64, res1=0; non-watchdog build stays in ESPERA.
REQ-036 reset asserted in ESPERA -> outputs per REQ-025 immediately, no listo; next sol0 served normally.

Source files
------------

// File: rtl/arbitro_mul_pkg.sv
// Shared types and default sizing for the arbitro_mul two-requester multiplier arbiter.
package arbitro_mul_pkg;

  typedef enum logic [1:0] {
    LIBRE   = 2'd0,
    LANZA   = 2'd1,
    ESPERA  = 2'd2,
    ENTREGA = 2'd3
  } estado_t;

  localparam int ANCHO_DEF = 4;
  localparam int TMAX_DEF  = 64;

endpackage

// File: rtl/prioridad_rr.sv
// Two-way round-robin pick: a lone request wins, a tie goes to whoever was not served last.
module prioridad_rr (
  input  logic sol0,
  input  logic sol1,
  input  logic ultimo,
  output logic grant
);

  always_comb begin
    grant = 1'b0;
    if (sol0 && sol1) grant = ~ultimo;
    else if (sol1)    grant = 1'b1;
  end

endmodule

// File: rtl/arbitro_mul.sv
// Arbitrates two requesters onto one external multiplier; every output is registered.
// ARBITRO_MUL_WATCHDOG_EN adds an ESPERA timeout that returns a zero result with an error pulse.
module arbitro_mul
  import arbitro_mul_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF,
  parameter int TMAX  = TMAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sol0,
  input  logic               sol1,
  input  logic [ANCHO-1:0]   a0,
  input  logic [ANCHO-1:0]   b0,
  input  logic [ANCHO-1:0]   a1,
  input  logic [ANCHO-1:0]   b1,
  output logic               acep0,
  output logic               acep1,
  output logic [2*ANCHO-1:0] res0,
  output logic [2*ANCHO-1:0] res1,
  output logic               listo0,
  output logic               listo1,
  output logic               error0,
  output logic               error1,
  output logic               mul_start,
  output logic [ANCHO-1:0]   mul_a,
  output logic [ANCHO-1:0]   mul_b,
  input  logic [2*ANCHO-1:0] mul_res,
  input  logic               mul_fin
);

  if (TMAX < 1) begin : g_tmax_chk
    $error("arbitro_mul: TMAX must be at least 1");
  end

  estado_t estado;
  logic    g, ultimo, sel, fin_q, fin_sube, vence;

  prioridad_rr u_rr (
    .sol0   (sol0),
    .sol1   (sol1),
    .ultimo (ultimo),
    .grant  (sel)
  );

  // fin_q resets high so a done level left over from before reset never counts as an edge
  assign fin_sube = mul_fin & ~fin_q;

`ifdef ARBITRO_MUL_WATCHDOG_EN
  localparam int CW = $clog2(TMAX + 1);
  logic [CW-1:0] cnt;
  logic          tmo;

  assign vence = (estado == ESPERA) && !fin_sube && (cnt == CW'(TMAX - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      tmo    <= 1'b0;
      error0 <= 1'b0;
      error1 <= 1'b0;
    end else begin
      error0 <= 1'b0;
      error1 <= 1'b0;
      case (estado)
        LANZA:   begin cnt <= '0; tmo <= 1'b0; end
        ESPERA:  if (!fin_sube) begin
                   cnt <= cnt + 1'b1;
                   if (vence) tmo <= 1'b1;
                 end
        ENTREGA: begin error0 <= tmo & ~g; error1 <= tmo & g; end
        default: ;
      endcase
    end
  end
`else
  assign vence  = 1'b0;
  assign error0 = 1'b0;
  assign error1 = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado    <= LIBRE;
      g         <= 1'b0;
      ultimo    <= 1'b1;
      fin_q     <= 1'b1;
      acep0     <= 1'b0;
      acep1     <= 1'b0;
      listo0    <= 1'b0;
      listo1    <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      res0      <= '0;
      res1      <= '0;
    end else begin
      fin_q     <= mul_fin;
      acep0     <= 1'b0;
      acep1     <= 1'b0;
      listo0    <= 1'b0;
      listo1    <= 1'b0;
      mul_start <= 1'b0;
      case (estado)
        LIBRE: if (sol0 || sol1) begin
          g      <= sel;
          acep0  <= ~sel;
          acep1  <= sel;
          mul_a  <= sel ? a1 : a0;
          mul_b  <= sel ? b1 : b0;
          estado <= LANZA;
        end
        LANZA: begin
          mul_start <= 1'b1;
          estado    <= ESPERA;
        end
        ESPERA: if (fin_sube || vence) begin
          if (g) res1 <= vence ? '0 : mul_res;
          else   res0 <= vence ? '0 : mul_res;
          estado <= ENTREGA;
        end
        ENTREGA: begin
          listo0 <= ~g;
          listo1 <= g;
          ultimo <= g;
          estado <= LIBRE;
        end
        default: estado <= LIBRE;
      endcase
    end
  end

endmodule
